contador_bcd4: RTL and testbench
================================

# contador_bcd4

Four-digit BCD up/down counter (0000–9999) that produces the digit nibbles consumed by the per-digit seven-segment decoders of the counter display. It divides the system clock to a count tick, synchronizes and edge-detects the front-panel switches and buttons, and advances the count with decimal carry/borrow between digits. Outputs are always legal BCD (0–9), so decoder codes A–F never appear on the display.

## Interface

- `CLK_HZ`, default 50_000_000: system clock frequency.
- `TICK_HZ`, default 10: count rate in auto mode. `DIV = CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `CLK`  in  1  system clock, rising-edge active.
- `RST_N`  in  1  reset. One clock; reset is asynchronous and active-low.
- `EN`  in  1  auto-count enable (switch level, asynchronous to `CLK`).
- `UP`  in  1  direction (switch level, asynchronous): 1 = up, 0 = down.
- `CLR`  in  1  clear button (asynchronous, active-high, acts on rising edge).
- `STEP`  in  1  single-step button (asynchronous, active-high, acts on rising edge).
- `Z0`  out  4  units digit, BCD.
- `Z1`  out  4  tens digit, BCD.
- `Z2`  out  4  hundreds digit, BCD.
- `Z3`  out  4  thousands digit, BCD.
- `TICK`  out  1  one-cycle prescaler pulse.
- `CARRY`  out  1  one-cycle pulse on wrap (9999→0000 up, 0000→9999 down).

## Operation

- **Reset (`RST_N` = 0):** takes effect immediately, independent of `CLK`.
  - `Z0`–`Z3` = 0, `TICK` = 0, `CARRY` = 0.
  - Prescaler = 0; all synchronizer and edge-detect flops = 0.
  - Applies equally when reset is asserted mid-count.
- **Input conditioning:** `EN`, `UP`, `CLR` and `STEP` each pass through a 2-flop synchronizer (s1, s2) plus a history flop (s3).
  - Rising-edge pulse = s2 & ~s3.
  - Level inputs (`EN`, `UP`) use s2.
- **Prescaler:** counts 0..DIV-1 and wraps to 0.
  - `TICK` is a registered output, high for exactly one cycle each time the prescaler wraps, i.e. period DIV cycles.
  - A `CLR` pulse forces the prescaler to 0 and suppresses `TICK` that cycle.
- **Advance event:**
  - (`TICK` & `EN_s`), or
  - (`STEP` pulse & ~`EN_s`).
  - A `STEP` pulse while `EN_s` = 1 is ignored.
- **Priority per cycle:** `CLR` pulse > advance > hold. If `CLR` and an advance coincide, the count goes to 0000 and `CARRY` stays 0.
- **Up advance:**
  - `Z0`+1. At 9, `Z0` becomes 0 and carries into `Z1`; the carry ripples likewise through `Z3`.
  - At 9999, the count becomes 0000 and `CARRY` = 1.
- **Down advance:**
  - `Z0`-1. At 0, `Z0` becomes 9 and borrows from `Z1`, rippling likewise.
  - At 0000, the count becomes 9999 and `CARRY` = 1.
- Direction is sampled from `UP_s` in the cycle of the advance. A direction change alone never moves the count.
- **BCD invariant:** digits never leave 0–9. No internal binary-to-BCD conversion; each digit is a 4-bit mod-10 counter chained by carry/borrow enables.

## Timing

- All state is registered on the `CLK` rising edge. `Z0`–`Z3`, `TICK` and `CARRY` come directly from flops (no combinational path from inputs).
- **Button latency:** an input first sampled high at edge k gives s2 = 1 after k+1. The edge pulse is valid during cycle k+1→k+2. The effect (count change or clear) is visible on `Z` after edge k+2.
- A button held high produces exactly one pulse. Re-arming requires the synchronized input to return to 0 for at least one cycle.
- **`CARRY`:** high for exactly the one cycle immediately after the wrap edge, concurrent with the new 0000/9999 value. It is low otherwise, including after `CLR`.
- **`TICK` → `Z`:** the count updates on the edge following the cycle in which `TICK` = 1.
- **`EN` changes:** take effect 2 edges after first sampling. A `TICK` already in flight follows the synchronized `EN_s` in its cycle.
- **No debounce:** switch bounce produces multiple pulses. Debouncing is upstream board logic.

## Test plan

Directed scenarios use `CLK_HZ`=10, `TICK_HZ`=1 (DIV=10) unless noted.

- **Reset:** assert `RST_N`=0 mid-count at 0347 between clock edges → `Z` = 0000 and `TICK`/`CARRY` = 0 immediately. Release → first `TICK` 10 cycles after the first edge following release.
- **Auto up with carry chain:** `EN`=1, `UP`=1, starting at 0098 → 0099, then 0100 on successive ticks. Starting at 9998 → 9999, then 0000 with `CARRY` high one cycle only.
- **Auto down with borrow:** `EN`=1, `UP`=0 from 0001 → 0000, then 9999 with `CARRY`=1. From 1000 → 0999.
- **Single step:** `EN`=0, pulse `STEP` high for 5 cycles → exactly one increment, visible after the 3rd edge counting from the first sampling edge. With `EN`=1, a `STEP` pulse changes nothing beyond the normal ticks.
- **Clear collision:** time the `CLR` edge pulse to coincide with a `TICK` at count 9999 → `Z` = 0000, `CARRY`=0, and the prescaler restarts so the next `TICK` is 10 cycles later.
- **BCD invariant sweep:** run `TICK_HZ`=`CLK_HZ`/2 for 20 000 advances up, then down → every digit stays in 0–9, exactly 2 `CARRY` pulses per direction, and the final value equals the start value.

Source files
------------

// File: rtl/contador_bcd4.sv
// contador_bcd4: four-digit BCD up/down counter with tick prescaler and synchronized panel inputs
module contador_bcd4 #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    input  logic       step,
    output logic [3:0] z0,
    output logic [3:0] z1,
    output logic [3:0] z2,
    output logic [3:0] z3,
    output logic       tick,
    output logic       carry
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [3:0] s1, s2, s3;
    logic en_s, up_s, clr_p, step_p, adv, rip, wrap;
    logic [PW-1:0] pre;
    logic [3:0][3:0] d, dn;

    assign en_s   = s2[0];
    assign up_s   = s2[1];
    assign clr_p  = s2[2] & ~s3[2];
    assign step_p = s2[3] & ~s3[3];
    assign adv    = (tick & en_s) | (step_p & ~en_s);
    assign {z3, z2, z1, z0} = d;

    // two-flop synchronizer plus history flop for {step, clr, up, en}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= {step, clr, up, en};
            s2 <= s1;
            s3 <= s2;
        end
    end

    // prescaler wraps every DIV cycles; a clear restarts it and swallows that cycle's tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre  <= '0;
            tick <= 1'b0;
        end else if (clr_p) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            pre  <= (pre == LAST) ? '0 : pre + 1'b1;
            tick <= (pre == LAST);
        end
    end

    // mod-10 digits chained by carry/borrow; rip survives to the end only on a full wrap
    always_comb begin
        rip = adv;
        dn  = d;
        for (int i = 0; i < 4; i++) begin
            dn[i] = rip ? (up_s ? ((d[i] == 4'd9) ? 4'd0 : d[i] + 4'd1)
                                : ((d[i] == 4'd0) ? 4'd9 : d[i] - 4'd1)) : d[i];
            rip = rip & (up_s ? (d[i] == 4'd9) : (d[i] == 4'd0));
        end
        wrap = rip;
    end

    // count register: clear beats advance, and a clear never raises carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d     <= '0;
            carry <= 1'b0;
        end else if (clr_p) begin
            d     <= '0;
            carry <= 1'b0;
        end else begin
            d     <= dn;
            carry <= wrap;
        end
    end
endmodule

// File: tb/tb_contador_bcd4.sv
// tb_contador_bcd4: directed scoreboard bench for the BCD up/down counter
module tb_contador_bcd4;
    typedef struct {
        string       tag;
        logic [15:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, en, up, clr, step;
    logic rst2_n, en2, up2, clr2, step2;
    logic [3:0] z0, z1, z2, z3, y0, y1, y2, y3;
    logic tick, carry, tick2, carry2;
    logic [15:0] val, val2;
    int total = 0;
    int bad = 0;
    int carries2 = 0;
    int badbcd = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign val  = {z3, z2, z1, z0};
    assign val2 = {y3, y2, y1, y0};

    contador_bcd4 #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .step(step),
        .z0(z0), .z1(z1), .z2(z2), .z3(z3), .tick(tick), .carry(carry)
    );

    contador_bcd4 #(.CLK_HZ(10), .TICK_HZ(5)) dut2 (
        .clk(clk), .rst_n(rst2_n), .en(en2), .up(up2), .clr(clr2), .step(step2),
        .z0(y0), .z1(y1), .z2(y2), .z3(y3), .tick(tick2), .carry(carry2)
    );

    // carry-pulse tally and digit-range watch on the sweep counter
    always @(negedge clk) begin
        if (carry2 === 1'b1) carries2 <= carries2 + 1;
        if (y0 > 4'd9 || y1 > 4'd9 || y2 > 4'd9 || y3 > 4'd9 ||
            z0 > 4'd9 || z1 > 4'd9 || z2 > 4'd9 || z3 > 4'd9) badbcd <= badbcd + 1;
    end

    task automatic push(input string t, input logic [15:0] v);
        sb.push_back('{t, v});
    endtask

    task automatic pop_cmp(input logic [15:0] o);
        exp_t e;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL sb_empty got=%h", o);
            return;
        end
        e = sb.pop_front();
        assert (o === e.v) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", e.tag, o, e.v);
        end
    endtask

    task automatic tick_wait(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 30);
        if (tick !== 1'b1) begin
            push("tick_timeout", 16'd1);
            pop_cmp({15'd0, tick});
        end
    endtask

    task automatic tick2_wait;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick2 !== 1'b1 && n < 6);
        if (tick2 !== 1'b1) begin
            push("tick2_timeout", 16'd1);
            pop_cmp({15'd0, tick2});
        end
    endtask

    task automatic step_once;
        repeat (3) @(negedge clk);
        step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
    endtask

    task automatic run2(input int n, input logic dir);
        tick2_wait();
        up2 = dir;
        en2 = 1'b1;
        repeat (n) tick2_wait();
        en2 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        int c0;
        rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; step = 1'b0;
        rst2_n = 1'b0; en2 = 1'b0; up2 = 1'b1; clr2 = 1'b0; step2 = 1'b0;
        #12;
        push("rst_z", 16'h0000);  pop_cmp(val);
        push("rst_tick", 16'd0);  pop_cmp({15'd0, tick});
        push("rst_carry", 16'd0); pop_cmp({15'd0, carry});
        @(negedge clk);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        tick_wait(n);
        push("first_tick", 16'd10); pop_cmp(16'(n));

        repeat (3) @(negedge clk);
        step = 1'b1;
        @(negedge clk); push("step_e1", 16'h0000); pop_cmp(val);
        @(negedge clk); push("step_e2", 16'h0000); pop_cmp(val);
        @(negedge clk); push("step_e3", 16'h0001); pop_cmp(val);
        repeat (2) @(negedge clk);
        step = 1'b0;
        repeat (5) @(negedge clk);
        push("step_once", 16'h0001); pop_cmp(val);

        up = 1'b0;
        step_once();
        push("step_dn", 16'h0000); pop_cmp(val);
        step_once();
        push("step_wrap", 16'h9999); pop_cmp(val);
        push("step_wrap_carry", 16'd1); pop_cmp({15'd0, carry});
        @(negedge clk);
        push("carry_one_cycle", 16'd0); pop_cmp({15'd0, carry});

        up = 1'b1;
        repeat (3) @(negedge clk);
        tick_wait(n);
        en = 1'b1;
        repeat (8) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        push("clr_coincide_tick", 16'd1); pop_cmp({15'd0, tick});
        push("clr_pre_z", 16'h9999); pop_cmp(val);
        clr = 1'b0;
        @(negedge clk);
        push("clr_z", 16'h0000); pop_cmp(val);
        push("clr_carry", 16'd0); pop_cmp({15'd0, carry});
        tick_wait(n);
        push("clr_restart", 16'd10); pop_cmp(16'(n));

        repeat (97) tick_wait(n);
        @(negedge clk); push("up_0098", 16'h0098); pop_cmp(val);
        tick_wait(n);
        @(negedge clk); push("up_0099", 16'h0099); pop_cmp(val);
        tick_wait(n);
        @(negedge clk); push("up_0100", 16'h0100); pop_cmp(val);
        push("up_no_carry", 16'd0); pop_cmp({15'd0, carry});

        tick_wait(n);
        step = 1'b1;
        repeat (2) @(negedge clk);
        step = 1'b0;
        repeat (6) @(negedge clk);
        push("en_step_ignored", 16'h0101); pop_cmp(val);

        tick_wait(n);
        up = 1'b0;
        repeat (101) tick_wait(n);
        @(negedge clk); push("dn_0001", 16'h0001); pop_cmp(val);
        tick_wait(n);
        @(negedge clk); push("dn_0000", 16'h0000); pop_cmp(val);
        tick_wait(n);
        @(negedge clk); push("dn_wrap", 16'h9999); pop_cmp(val);
        push("dn_wrap_carry", 16'd1); pop_cmp({15'd0, carry});
        @(negedge clk);
        push("dn_carry_drop", 16'd0); pop_cmp({15'd0, carry});
        tick_wait(n);
        @(negedge clk); push("dn_9998", 16'h9998); pop_cmp(val);

        #2 rst_n = 1'b0;
        #1;
        push("mid_rst_z", 16'h0000);  pop_cmp(val);
        push("mid_rst_tick", 16'd0);  pop_cmp({15'd0, tick});
        push("mid_rst_carry", 16'd0); pop_cmp({15'd0, carry});
        @(negedge clk);
        rst_n = 1'b1;
        tick_wait(n);
        push("mid_rst_first_tick", 16'd10); pop_cmp(16'(n));

        c0 = carries2;
        push("sweep_up_z", 16'h0000);
        run2(20000, 1'b1);
        pop_cmp(val2);
        push("sweep_up_carries", 16'd2); pop_cmp(16'(carries2 - c0));
        c0 = carries2;
        push("sweep_dn_1000", 16'h1000);
        run2(9000, 1'b0);
        pop_cmp(val2);
        push("sweep_dn_0999", 16'h0999);
        run2(1, 1'b0);
        pop_cmp(val2);
        push("sweep_dn_z", 16'h0000);
        run2(10999, 1'b0);
        pop_cmp(val2);
        push("sweep_dn_carries", 16'd2); pop_cmp(16'(carries2 - c0));
        push("bcd_range", 16'd0); pop_cmp(16'(badbcd));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
